// File: rtl/apb_pkg.sv
// Shared APB definitions: sequencer state encoding, default bus widths and
// the timeout counter width helper.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } apb_state_t;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    // Counter holds 0..TIMEOUT-1; never narrower than one bit.
    function automatic int tmo_cnt_w(input int timeout);
        return ($clog2(timeout) < 1) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request bit at or above ptr,
// wrapping from N_REQ-1 back to 0.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] winner,
    output logic [PTR_W-1:0] idx
);

    logic             found;
    logic [PTR_W-1:0] pos;

    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        pos    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pos = PTR_W'((int'(ptr) + i) % N_REQ);
            if (!found && req[pos]) begin
                found       = 1'b1;
                winner[pos] = 1'b1;
                idx         = pos;
            end
        end
    end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter that shares one APB master port among N_REQ requesters
// and runs the SETUP/ACCESS handshake on the winner's behalf.
module apb_rr_arbiter
    import apb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 64
) (
    input  logic                       PCLK,
    input  logic                       PRESET,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr,
    input  logic [N_REQ*DATA_W-1:0]    req_wdata,
    input  logic [N_REQ-1:0]           req_write,
    output logic [N_REQ-1:0]           gnt,
    output logic [N_REQ-1:0]           done,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rsp_err,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [ADDR_W-1:0]          PADDR,
    output logic [DATA_W-1:0]          PWDATA,
    input  logic [DATA_W-1:0]          PRDATA,
    input  logic                       PREADY,
    input  logic                       PSLVERR
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = tmo_cnt_w(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

    apb_state_t       state;
    logic [PTR_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
    logic [N_REQ-1:0] winner;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] ptr_next;

    rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req    (req),
        .ptr    (ptr),
        .winner (winner),
        .idx    (win_idx)
    );

    assign ptr_next = (win_idx == PTR_LAST) ? '0 : win_idx + PTR_W'(1);

    // PADDR/PWDATA/PWRITE double as the holding registers: loaded only at
    // grant, so they stay stable through SETUP/ACCESS and keep their value after.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            gnt       <= '0;
            done      <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        PADDR   <= req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
                        PWDATA  <= req_wdata[int'(win_idx)*DATA_W +: DATA_W];
                        PWRITE  <= req_write[win_idx];
                        gnt     <= winner;
                        ptr     <= ptr_next;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    cnt     <= '0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    cnt <= cnt + CNT_W'(1);
                    if (PREADY) begin
                        rsp_rdata <= PRDATA;
                        rsp_err   <= PSLVERR;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        done      <= gnt;
                        state     <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        // Abort: report error with zeroed data.
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        done      <= gnt;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= '0;
                    gnt   <= '0;
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter (N_REQ=4, TIMEOUT=8): single transfer,
// fairness, wait states, slave error, timeout and reset mid-ACCESS.
module tb_apb_rr_arbiter;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic [N-1:0]      req;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      req_write;
    logic [N-1:0]      gnt;
    logic [N-1:0]      done;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [AW-1:0]     PADDR;
    logic [DW-1:0]     PWDATA;
    logic [DW-1:0]     PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    int ncmp = 0;
    int nerr = 0;

    apb_rr_arbiter #(
        .N_REQ   (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TMO)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req       (req),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_write (req_write),
        .gnt       (gnt),
        .done      (done),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gnt"},   64'(gnt), 64'h0);
        chk({tag, "_done"},  64'(done), 64'h0);
        chk({tag, "_psel"},  64'(PSEL), 64'h0);
        chk({tag, "_pen"},   64'(PENABLE), 64'h0);
        chk({tag, "_pwr"},   64'(PWRITE), 64'h0);
        chk({tag, "_paddr"}, 64'(PADDR), 64'h0);
        chk({tag, "_pwd"},   64'(PWDATA), 64'h0);
        chk({tag, "_rdata"}, 64'(rsp_rdata), 64'h0);
        chk({tag, "_err"},   64'(rsp_err), 64'h0);
    endtask

    initial begin
        PRESET    = 1'b1;
        req       = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_write = '0;
        PRDATA    = '0;
        PREADY    = 1'b1;
        PSLVERR   = 1'b0;
        tick();
        tick();
        chk_reset_vals("rst");

        // Single requester: write 0x1 to 0x1000 from requester 1
        PRESET = 1'b0;
        req_addr[1*AW +: AW]  = 32'h0000_1000;
        req_wdata[1*DW +: DW] = 32'h0000_0001;
        req_write[1]          = 1'b1;
        req                   = 4'b0010;
        tick();                                    // T+1 SETUP
        chk("s_setup_gnt",   64'(gnt), 64'h2);
        chk("s_setup_psel",  64'(PSEL), 64'h1);
        chk("s_setup_pen",   64'(PENABLE), 64'h0);
        chk("s_setup_paddr", 64'(PADDR), 64'h1000);
        chk("s_setup_pwd",   64'(PWDATA), 64'h1);
        chk("s_setup_pwr",   64'(PWRITE), 64'h1);
        tick();                                    // T+2 ACCESS
        chk("s_acc_gnt",   64'(gnt), 64'h2);
        chk("s_acc_pen",   64'(PENABLE), 64'h1);
        chk("s_acc_paddr", 64'(PADDR), 64'h1000);
        chk("s_acc_done",  64'(done), 64'h0);
        tick();                                    // T+3 DONE
        chk("s_done",      64'(done), 64'h2);
        chk("s_done_gnt",  64'(gnt), 64'h2);
        chk("s_done_err",  64'(rsp_err), 64'h0);
        chk("s_done_psel", 64'(PSEL), 64'h0);
        req = '0;
        tick();                                    // T+4 IDLE
        chk("s_idle_gnt",  64'(gnt), 64'h0);
        chk("s_idle_done", 64'(done), 64'h0);
        chk("s_idle_paddr_hold", 64'(PADDR), 64'h1000);

        // Fairness: all four held from reset, each drops after its done
        PRESET = 1'b1;
        req    = 4'b1111;
        tick();
        PRESET = 1'b0;
        for (int k = 0; k < N; k++) begin
            tick();
            chk($sformatf("fair_gnt%0d", k), 64'(gnt), 64'(1 << k));
            tick();
            tick();
            chk($sformatf("fair_done%0d", k), 64'(done), 64'(1 << k));
            req[k] = 1'b0;
            tick();
            chk($sformatf("fair_idle%0d", k), 64'(gnt), 64'h0);
        end
        req = 4'b1001;                             // ptr back at 0
        tick();
        chk("fair2_gnt0", 64'(gnt), 64'h1);
        tick();
        tick();
        chk("fair2_done0", 64'(done), 64'h1);
        req[0] = 1'b0;
        tick();
        tick();
        chk("fair2_gnt3", 64'(gnt), 64'h8);
        tick();
        tick();
        chk("fair2_done3", 64'(done), 64'h8);
        req[3] = 1'b0;
        tick();

        // Wait states + read: 3 low ACCESS cycles, done at T+6
        req_addr[0*AW +: AW] = 32'h0000_2000;
        req_write[0]         = 1'b0;
        PREADY               = 1'b0;
        req                  = 4'b0001;
        tick();                                    // T+1
        tick();                                    // T+2 ACCESS
        chk("ws_pwr",   64'(PWRITE), 64'h0);
        chk("ws_paddr", 64'(PADDR), 64'h2000);
        tick();                                    // T+3
        tick();                                    // T+4
        tick();                                    // T+5
        chk("ws_nodone", 64'(done), 64'h0);
        chk("ws_pen",    64'(PENABLE), 64'h1);
        PREADY = 1'b1;
        PRDATA = 32'hDEAD_BEEF;
        tick();                                    // T+6 DONE
        chk("ws_done",  64'(done), 64'h1);
        chk("ws_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
        chk("ws_err",   64'(rsp_err), 64'h0);
        req = '0;
        tick();

        // Slave error on requester 1, then requester 2 proceeds cleanly
        PSLVERR = 1'b1;
        PRDATA  = 32'h0000_00AA;
        req     = 4'b0110;
        tick();
        chk("err_gnt1", 64'(gnt), 64'h2);
        tick();
        tick();
        chk("err_done1", 64'(done), 64'h2);
        chk("err_err1",  64'(rsp_err), 64'h1);
        req[1]  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = 32'h0000_0055;
        tick();
        chk("err_idle", 64'(gnt), 64'h0);
        tick();
        chk("err_gnt2", 64'(gnt), 64'h4);
        tick();
        tick();
        chk("err_done2",  64'(done), 64'h4);
        chk("err_err2",   64'(rsp_err), 64'h0);
        chk("err_rdata2", 64'(rsp_rdata), 64'h55);
        req[2] = 1'b0;
        tick();

        // Timeout: PREADY held low, done exactly TMO+1 cycles after SETUP
        PREADY = 1'b0;
        PRDATA = 32'h1234_5678;
        req    = 4'b0001;
        tick();                                    // SETUP
        chk("to_gnt", 64'(gnt), 64'h1);
        for (int c = 1; c <= TMO; c++) begin
            tick();
            chk($sformatf("to_wait%0d", c), 64'({done, PSEL}), 64'h1);
        end
        tick();                                    // SETUP + TMO + 1
        chk("to_done",  64'(done), 64'h1);
        chk("to_err",   64'(rsp_err), 64'h1);
        chk("to_rdata", 64'(rsp_rdata), 64'h0);
        chk("to_psel",  64'(PSEL), 64'h0);
        req = '0;
        tick();

        // Reset mid-ACCESS, then 1111 granted to requester 0 first
        req = 4'b1111;
        tick();
        chk("rm_gnt", 64'(gnt), 64'h2);
        tick();
        chk("rm_acc", 64'(PENABLE), 64'h1);
        PRESET = 1'b1;
        tick();
        chk_reset_vals("rm");
        PRESET = 1'b0;
        tick();
        chk("rm_regnt", 64'(gnt), 64'h1);
        tick();
        chk("rm_after_psel", 64'(PSEL), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/apb_rr_arbiter.md
# apb_rr_arbiter

Round-robin arbiter and transfer sequencer that shares one APB master port among `N_REQ` requesters. It samples pending requests and grants one requester, fair-rotating after each grant. It then runs the APB SETUP/ACCESS protocol on that requester's behalf and returns read data and error status with a one-cycle completion pulse. It sits between the interconnect's requester ports and the APB bus toward the slaves.

## Interface
- Clocking: one clock; reset is synchronous and active-high.
- Parameters:
  - `N_REQ`, default 4: number of requesters, 2..16.
  - `ADDR_W`, default 32: APB address width.
  - `DATA_W`, default 32: APB data width.
  - `TIMEOUT`, default 64: maximum ACCESS cycles without `PREADY` before abort, ≥2.
- Ports:
  - `PCLK` input, 1: clock, all logic on rising edge.
  - `PRESET` input, 1: synchronous active-high reset.
  - `req` input, `N_REQ`: per-requester transfer request, level; held until `done`.
  - `req_addr` input, `N_REQ*ADDR_W`: packed per-requester address; slice i belongs to requester i.
  - `req_wdata` input, `N_REQ*DATA_W`: packed per-requester write data.
  - `req_write` input, `N_REQ`: 1 = write, 0 = read.
  - `gnt` output, `N_REQ`: one-hot grant; held from SETUP through DONE.
  - `done` output, `N_REQ`: one-hot, one-cycle completion pulse to the granted requester.
  - `rsp_rdata` output, `DATA_W`: read data, valid while any `done` bit is set.
  - `rsp_err` output, 1: slave error or timeout, valid while any `done` bit is set.
  - `PSEL` output, 1: APB select.
  - `PENABLE` output, 1: APB enable.
  - `PWRITE` output, 1: APB direction.
  - `PADDR` output, `ADDR_W`: APB address.
  - `PWDATA` output, `DATA_W`: APB write data.
  - `PRDATA` input, `DATA_W`: APB read data.
  - `PREADY` input, 1: slave ready.
  - `PSLVERR` input, 1: slave error, sampled only with `PREADY`.

## Operation
- **FSM states:** IDLE, SETUP, ACCESS, DONE.
- **IDLE:**
  - If `req` is nonzero, select the winner: the first set bit scanning from `ptr` upward, wrapping at `N_REQ-1` → 0.
  - On that edge:
    - capture the winner's addr/wdata/write into holding registers;
    - set `gnt` to the winner;
    - set `ptr` to winner+1 mod `N_REQ`;
    - go to SETUP.
  - If `req` is 0, stay in IDLE; `ptr` is unchanged.
- **SETUP:** `PSEL`=1, `PENABLE`=0; always go to ACCESS.
- **ACCESS:** `PSEL`=1, `PENABLE`=1; the timeout counter increments each cycle.
  - `PREADY`=1: capture `PRDATA` into `rsp_rdata` and `PSLVERR` into `rsp_err`; go to DONE.
  - Counter reaches `TIMEOUT-1` with `PREADY`=0: `rsp_rdata`=0, `rsp_err`=1; go to DONE.
- **DONE:**
  - `PSEL`=`PENABLE`=0; `done`=`gnt` for exactly one cycle.
  - Go to IDLE; clear `gnt` and the timeout counter.
- **No retry:** errors are reported, never retried.
- **Bus outputs:** `PADDR`/`PWDATA`/`PWRITE` are driven from the holding registers. They are stable from SETUP through ACCESS and keep their last value otherwise.
- **Requester obligation:** drop `req` on the edge at which it samples `done`=1. The next IDLE cycle then never sees a stale request.
- **Simultaneous requests:** only one winner per IDLE cycle. Losers keep `req` high and are served in rotation order. No requester waits more than `N_REQ-1` other transfers.
- **Request changes after grant:** changes to `req` or payload are ignored until the next IDLE. A requester that deasserts `req` while granted still completes its transfer.
- **Reset:**
  - The reset values below apply at any point, including mid-ACCESS.
  - The bus transaction is abandoned silently; no `done` is issued.
  - The slave sees `PSEL` fall.

## Timing
- Outputs decode from registered state/holding registers; no input→output combinational path.
- **Reset values:**
  - state IDLE, `ptr`=0;
  - `gnt`=0, `done`=0;
  - `PSEL`=`PENABLE`=`PWRITE`=0, `PADDR`=0, `PWDATA`=0;
  - `rsp_rdata`=0, `rsp_err`=0;
  - timeout counter 0.
- **Latency (`PREADY` tied high), `req` seen in IDLE cycle T:**
  - T+1: SETUP;
  - T+2: ACCESS;
  - T+3: DONE with `done` high;
  - T+4: IDLE.
- Each wait state adds one cycle in ACCESS. Steady-state throughput with continuous requests is one transfer per 4 cycles.
- **Timeout:** `done`/`rsp_err` assert exactly `TIMEOUT`+1 cycles after SETUP.

## Structure
- **Shared package `apb_pkg`:**
  - `apb_state_t` enum {IDLE, SETUP, ACCESS, DONE};
  - default `ADDR_W`/`DATA_W` constants;
  - timeout counter width helper, `$clog2(TIMEOUT)`.
- **Sub-module `rr_picker`:** combinational; inputs `req` and `ptr`; outputs one-hot `winner` and its index. Parameterised by `N_REQ`; reusable by other interconnect arbiters.
- **`apb_rr_arbiter` contains:** the FSM, holding registers, pointer, timeout counter and response registers.

## Test plan
- **Single requester:** `req`=4'b0010, addr 0x1000, write, data 0x1, `PREADY`=1 → `gnt`=0010 for 3 cycles. `PADDR`=0x1000, `PWDATA`=0x1, `PWRITE`=1 in SETUP/ACCESS; `done`=0010 at T+3, `rsp_err`=0.
- **Fairness:** all four `req` held from reset, each dropping after its `done` → grant order 0,1,2,3. Then re-raise `req[0]`,`req[3]` with `ptr`=0 → order 0,3.
- **Wait states and read:** read to 0x2000, `PREADY` low for 3 ACCESS cycles, then high with `PRDATA`=0xDEADBEEF → `done` at T+6, `rsp_rdata`=0xDEADBEEF.
- **Slave error:** `PREADY`=`PSLVERR`=1 in first ACCESS → `rsp_err`=1; FSM returns to IDLE; next requester proceeds normally.
- **Timeout:** `TIMEOUT`=8, `PREADY` held 0 → `done` with `rsp_err`=1, `rsp_rdata`=0 exactly 9 cycles after SETUP; `PSEL` drops in DONE.
- **Reset mid-ACCESS:** assert `PRESET` in ACCESS → next cycle all outputs at reset values, no `done`. After release, pending `req`=1111 is granted to requester 0 first.
